// File: rtl/alu_operand_loader.sv
// Operand loader for the combinational ALU: debounced buttons load A, B, then opcode (optional opcode legality check under ALU_LOADER_OPCHECK_EN).
// Latency: button to register = 2 sync + DEBOUNCE_CYCLES + 1 cycles; opcode load to o_valid 1 cycle; o_result updates the cycle after o_valid.
// Backpressure: none; button strobes for buttons the current state does not expect are dropped.
module alu_operand_loader #(
    parameter int N_BITS          = 8,
    parameter int N_OP            = 6,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [N_BITS-1:0] i_sw,
    input  logic [2:0]        i_btn,
    input  logic [N_BITS-1:0] i_res,
    output logic [N_BITS-1:0] o_A,
    output logic [N_BITS-1:0] o_B,
    output logic [N_OP-1:0]   o_Op,
    output logic              o_valid,
    output logic [N_BITS-1:0] o_result,
    output logic [1:0]        o_state,
    output logic              o_err
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        ISSUE   = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [2:0]      sync_a;
    logic [2:0]      sync_b;
    logic [2:0]      strobe;
    logic [CW-1:0]   cnt [3];
    logic            op_ok;
    logic [N_OP-1:0] op_sel;

    assign op_sel = i_sw[N_OP-1:0];

    // Strobe is registered so it is high exactly on the cycle the counter sits at DB_MAX.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
            strobe <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            sync_a <= i_btn;
            sync_b <= sync_a;
            for (int i = 0; i < 3; i++) begin
                if (!sync_b[i])
                    cnt[i] <= '0;
                else if (cnt[i] != DB_MAX)
                    cnt[i] <= cnt[i] + 1'b1;
                strobe[i] <= sync_b[i] && (cnt[i] == DB_MAX - 1'b1);
            end
        end
    end

`ifdef ALU_LOADER_OPCHECK_EN
    logic [5:0] op6;
    logic       err_q;

    assign op6 = 6'(op_sel);

    always_comb begin
        op_ok = 1'b0;
        case (op6)
            6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b100111, 6'b000011, 6'b000010: op_ok = 1'b1;
            default: op_ok = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            err_q <= 1'b0;
        else if (state_q == WAIT_OP && strobe[2])
            err_q <= !op_ok;
    end

    assign o_err = err_q;
`else
    assign op_ok = 1'b1;
    assign o_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            state_q <= WAIT_A;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_A:  if (strobe[0]) state_d = WAIT_B;
            WAIT_B:  if (strobe[1]) state_d = WAIT_OP;
            WAIT_OP: if (strobe[2] && op_ok) state_d = ISSUE;
            ISSUE:   state_d = WAIT_A;
            default: state_d = WAIT_A;
        endcase
    end

    always_comb begin
        o_valid = (state_q == ISSUE);
        o_state = state_q;
    end

    // i_sw is only sampled on the accepted strobe; the ALU is combinational so i_res is settled in ISSUE.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_A      <= '0;
            o_B      <= '0;
            o_Op     <= '0;
            o_result <= '0;
        end else begin
            case (state_q)
                WAIT_A:  if (strobe[0]) o_A <= i_sw;
                WAIT_B:  if (strobe[1]) o_B <= i_sw;
                WAIT_OP: if (strobe[2] && op_ok) o_Op <= op_sel;
                ISSUE:   o_result <= i_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a behavioural ALU and a result scoreboard.
module tb_alu_operand_loader;

    localparam int NB = 8;
    localparam int NO = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] sw = '0;
    logic [2:0]    btn = '0;
    logic [NB-1:0] res;
    logic [NB-1:0] a, b, result;
    logic [NO-1:0] op;
    logic          valid, err;
    logic [1:0]    state;

    int n_checks = 0;
    int n_fail = 0;
    int n_valid = 0;
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] exp_res;
    logic          chk_pending = 1'b0;
    logic [NB-1:0] ea, eb;
    logic [NO-1:0] eop;

    always #5 clk = ~clk;

    alu_operand_loader #(.N_BITS(NB), .N_OP(NO), .DEBOUNCE_CYCLES(4)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_sw(sw), .i_btn(btn), .i_res(res),
        .o_A(a), .o_B(b), .o_Op(op), .o_valid(valid), .o_result(result),
        .o_state(state), .o_err(err)
    );

    function automatic logic [NB-1:0] alu(input logic [NB-1:0] x, input logic [NB-1:0] y,
                                          input logic [NO-1:0] f);
        case (f)
            6'b100000: alu = x + y;
            6'b100010: alu = x - y;
            6'b100100: alu = x & y;
            6'b100101: alu = x | y;
            6'b100110: alu = x ^ y;
            6'b100111: alu = ~(x | y);
            6'b000011: alu = NB'($signed(x) >>> y);
            6'b000010: alu = x >> y;
            default:   alu = '0;
        endcase
    endfunction

    always_comb res = alu(a, b, op);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: pop on each o_valid, compare o_result one cycle later.
    always @(negedge clk) begin
        if (chk_pending) begin
            chk("result", 32'(result), 32'(exp_res));
            chk_pending = 1'b0;
        end
        if (valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(1), 32'(0));
            end else begin
                exp_res = exp_q.pop_front();
                chk_pending = 1'b1;
            end
        end
    end

    task automatic press(input int idx, input logic [NB-1:0] v, input int hold);
        @(negedge clk);
        sw = v;
        btn[idx] = 1'b1;
        repeat (hold) @(negedge clk);
        btn[idx] = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic run_seq(input logic [NB-1:0] va, input logic [NB-1:0] vb, input logic [NO-1:0] vop);
        ea = va; eb = vb; eop = vop;
        press(0, va, 10);
        press(1, vb, 10);
        exp_q.push_back(alu(va, vb, vop));
        press(2, NB'(vop), 10);
    endtask

    initial begin
        int vcount;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_a", 32'(a), 0);
        chk("rst_b", 32'(b), 0);
        chk("rst_op", 32'(op), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_state", 32'(state), 0);

        run_seq(8'd3, 8'd3, 6'b100000);
        chk("add_a", 32'(a), 3);
        chk("add_b", 32'(b), 3);
        chk("add_op", 32'(op), 32'(6'b100000));
        chk("add_result", 32'(result), 6);
        chk("add_state", 32'(state), 0);
        chk("add_valid_cnt", 32'(n_valid), 1);

        run_seq(8'd6, 8'd2, 6'b100010);
        chk("sub_result", 32'(result), 4);
        chk("sub_valid_cnt", 32'(n_valid), 2);

        press(2, 8'hA5, 50);
        chk("held_btn2_state", 32'(state), 0);
        chk("held_btn2_a", 32'(a), 6);
        chk("held_btn2_b", 32'(b), 2);
        chk("held_btn2_op", 32'(op), 32'(6'b100010));

        // Bounce: never stable for 4 cycles
        @(negedge clk);
        sw = 8'd9;
        btn[0] = 1'b1; repeat (3) @(negedge clk);
        btn[0] = 1'b0; repeat (1) @(negedge clk);
        btn[0] = 1'b1; repeat (3) @(negedge clk);
        btn[0] = 1'b0; repeat (6) @(negedge clk);
        chk("bounce_state", 32'(state), 0);
        chk("bounce_a", 32'(a), 6);
        press(0, 8'd9, 10);
        chk("debounced_state", 32'(state), 1);
        chk("debounced_a", 32'(a), 9);
        press(1, 8'd5, 10);
        exp_q.push_back(alu(8'd9, 8'd5, 6'b100000));
        press(2, 8'b0010_0000, 10);
        chk("bounce_seq_result", 32'(result), 14);

        press(0, 8'd15, 10);
        press(1, 8'd4, 10);
        chk("pre_rst_state", 32'(state), 2);
        chk("pre_rst_b", 32'(b), 4);
        vcount = n_valid;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_a", 32'(a), 0);
        chk("mid_rst_b", 32'(b), 0);
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_result", 32'(result), 0);
        repeat (10) @(negedge clk);
        chk("mid_rst_no_valid", 32'(n_valid), 32'(vcount));

`ifdef ALU_LOADER_OPCHECK_EN
        press(0, 8'd7, 10);
        press(1, 8'd2, 10);
        press(2, 8'b0011_1111, 10);
        chk("illegal_err", 32'(err), 1);
        chk("illegal_state", 32'(state), 2);
        chk("illegal_op", 32'(op), 0);
        exp_q.push_back(alu(8'd7, 8'd2, 6'b100110));
        press(2, 8'b0010_0110, 10);
        chk("legal_err", 32'(err), 0);
        chk("legal_result", 32'(result), 5);
`else
        run_seq(8'd7, 8'd2, 6'b111111);
        chk("noopcheck_err", 32'(err), 0);
        chk("noopcheck_op", 32'(op), 32'(6'b111111));
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        chk("no_pending", 32'(chk_pending), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
